// File: rtl/dist_filter.sv
// dist_filter: capture, range-reject and moving-average stage behind the HC-SR04 ranging interface.
// Optional proximity alarm with hysteresis is built when DIST_FILTER_ALARM_EN is defined.
module dist_filter #(
  parameter int unsigned LOG2_N  = 2,
  parameter logic [19:0] MAX_CM  = 20'd400
`ifdef DIST_FILTER_ALARM_EN
  ,
  parameter logic [19:0] NEAR_CM = 20'd20,
  parameter logic [19:0] HYST_CM = 20'd5
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ready,
  input  logic [19:0] distance_cm,
  input  logic        flush,
  output logic [19:0] avg_cm,
  output logic        avg_valid,
  output logic        filled,
  output logic [19:0] last_raw,
  output logic [7:0]  reject_cnt,
  output logic        near
);

  localparam int                N        = 1 << LOG2_N;
  localparam int unsigned       SUM_W    = 20 + LOG2_N;
  localparam int unsigned       CNT_W    = LOG2_N + 1;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(N);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
    return (v == CNT_FULL) ? v : v + 1'b1;
  endfunction

  function automatic logic [19:0] trunc_avg(input logic [SUM_W-1:0] s);
    return s[SUM_W-1:LOG2_N];
  endfunction

  logic                r_rdy_q;
  logic                r_rdy_q2;
  logic                w_cap;
  logic                w_rej_p0;

  logic                r_vld_p1;
  logic                r_rej_p1;
  logic [8:0]          r_smp_p1;
  logic [19:0]         r_last_raw;

  logic [SUM_W-1:0]    r_sum;
  logic [8:0]          r_buf [N];
  logic [LOG2_N-1:0]   r_ptr;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [8:0]          w_old;
  logic                w_acc_p1;
  logic                r_pub_p2;
  logic [7:0]          r_rej_cnt;

  logic [19:0]         w_avg_p2;
  logic [19:0]         r_avg;
  logic                r_avg_vld;
  logic                r_filled;

  // Edge detect: both taps reset high so an idle-high ready never looks like a new result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdy_q  <= 1'b1;
      r_rdy_q2 <= 1'b1;
    end else begin
      r_rdy_q  <= ready;
      r_rdy_q2 <= r_rdy_q;
    end
  end

  assign w_cap    = r_rdy_q & ~r_rdy_q2;
  assign w_rej_p0 = (distance_cm == 20'd0) || (distance_cm > MAX_CM);

  // S1 capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1   <= 1'b0;
      r_rej_p1   <= 1'b0;
      r_smp_p1   <= '0;
      r_last_raw <= '0;
    end else begin
      r_vld_p1 <= w_cap & ~flush;
      if (w_cap && !flush) begin
        r_rej_p1   <= w_rej_p0;
        r_smp_p1   <= distance_cm[8:0];
        r_last_raw <= distance_cm;
      end
    end
  end

  assign w_acc_p1  = r_vld_p1 & ~r_rej_p1;
  assign w_cnt_nxt = sat_inc_cnt(r_cnt);
  assign w_old     = r_buf[r_ptr];

  // S2 update: S2 is the sole writer of the window, so the slot read here is always current
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum     <= '0;
      r_ptr     <= '0;
      r_cnt     <= '0;
      r_pub_p2  <= 1'b0;
      r_rej_cnt <= '0;
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
    end else if (flush) begin
      r_sum    <= '0;
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_pub_p2 <= 1'b0;
      for (int i = 0; i < N; i++) r_buf[i] <= '0;
    end else begin
      r_pub_p2 <= w_acc_p1 && (w_cnt_nxt == CNT_FULL);
      if (w_acc_p1) begin
        r_sum        <= r_sum - SUM_W'(w_old) + SUM_W'(r_smp_p1);
        r_buf[r_ptr] <= r_smp_p1;
        r_ptr        <= r_ptr + 1'b1;
        r_cnt        <= w_cnt_nxt;
      end
      if (r_vld_p1 && r_rej_p1) r_rej_cnt <= sat_inc8(r_rej_cnt);
    end
  end

  assign w_avg_p2 = trunc_avg(r_sum);

  // S3 publish
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_avg     <= '0;
      r_avg_vld <= 1'b0;
      r_filled  <= 1'b0;
    end else if (flush) begin
      r_avg     <= '0;
      r_avg_vld <= 1'b0;
      r_filled  <= 1'b0;
    end else begin
      r_avg_vld <= r_pub_p2;
      if (r_pub_p2) begin
        r_avg    <= w_avg_p2;
        r_filled <= (r_cnt == CNT_FULL);
      end
    end
  end

`ifdef DIST_FILTER_ALARM_EN
  logic r_near;

  function automatic logic near_next(input logic cur, input logic [19:0] a);
    if (a < NEAR_CM) return 1'b1;
    if (a >= NEAR_CM + HYST_CM) return 1'b0;
    return cur;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_near <= 1'b0;
    end else if (flush) begin
      r_near <= 1'b0;
    end else if (r_pub_p2) begin
      r_near <= near_next(r_near, w_avg_p2);
    end
  end

  assign near = r_near;
`else
  assign near = 1'b0;
`endif

  assign avg_cm     = r_avg;
  assign avg_valid  = r_avg_vld;
  assign filled     = r_filled;
  assign last_raw   = r_last_raw;
  assign reject_cnt = r_rej_cnt;

endmodule

// File: tb/tb_dist_filter.sv
// Directed bench for dist_filter: expected averages are queued by a window model and
// popped whenever the DUT strobes avg_valid.
module tb_dist_filter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready;
  logic [19:0] distance_cm;
  logic        flush;
  logic [19:0] avg_cm;
  logic        avg_valid;
  logic        filled;
  logic [19:0] last_raw;
  logic [7:0]  reject_cnt;
  logic        near;

  dist_filter dut (
    .clk         (clk),
    .rst         (rst),
    .ready       (ready),
    .distance_cm (distance_cm),
    .flush       (flush),
    .avg_cm      (avg_cm),
    .avg_valid   (avg_valid),
    .filled      (filled),
    .last_raw    (last_raw),
    .reject_cnt  (reject_cnt),
    .near        (near)
  );

  always #5 clk = ~clk;

  typedef struct {
    int avg;
    bit nr;
  } exp_t;

  exp_t sb[$];
  int   win[$];
  int   vectors = 0;
  int   errors  = 0;
  int   exp_rej = 0;
  int   exp_last = 0;
  int   cur_avg = 0;
  bit   cur_filled = 0;
  bit   cur_near = 0;
  bit   mnear = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (avg_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", {31'd0, avg_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        check("avg_cm", {12'd0, avg_cm}, e.avg);
        check("filled_at_valid", {31'd0, filled}, 32'd1);
        check("near_at_valid", {31'd0, near}, {31'd0, e.nr});
        cur_avg    = e.avg;
        cur_near   = e.nr;
        cur_filled = 1'b1;
      end
    end
  endtask

  task automatic model_sample(input int d);
    exp_t e;
    int   s;
    exp_last = d;
    if (d == 0 || d > 400) begin
      if (exp_rej < 255) exp_rej++;
    end else begin
      win.push_back(d);
      if (win.size() > 4) s = win.pop_front();
      if (win.size() == 4) begin
        s = 0;
        foreach (win[i]) s += win[i];
        e.avg = s / 4;
`ifdef DIST_FILTER_ALARM_EN
        if (e.avg < 20) mnear = 1'b1;
        else if (e.avg >= 25) mnear = 1'b0;
`endif
        e.nr = mnear;
        sb.push_back(e);
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_avg_cm"},     {12'd0, avg_cm},     32'd0);
    check({tag, "_avg_valid"},  {31'd0, avg_valid},  32'd0);
    check({tag, "_filled"},     {31'd0, filled},     32'd0);
    check({tag, "_last_raw"},   {12'd0, last_raw},   32'd0);
    check({tag, "_reject_cnt"}, {24'd0, reject_cnt}, 32'd0);
    check({tag, "_near"},       {31'd0, near},       32'd0);
  endtask

  // mode 0: normal, 1: flush coincident with cap, 2: rst pulse between E1 and E3
  task automatic measure(input int d, input int mode);
    ready = 1'b0;
    tick();
    if (mode == 0) model_sample(d);
    ready = 1'b1;
    distance_cm = 20'(d);
    tick();                                 // E0 sampled, cap now high
    if (mode == 1) flush = 1'b1;
    tick();                                 // E1
    flush = 1'b0;
    if (mode == 0) check("last_raw_e1", {12'd0, last_raw}, 32'(exp_last));
    if (mode == 1) begin
      win.delete();
      cur_avg = 0; cur_filled = 1'b0; cur_near = 1'b0; mnear = 1'b0;
    end
    if (mode == 2) begin
      rst = 1'b1;
      tick();
      check_all_zero("rst_mid");
      rst = 1'b0;
      win.delete();
      sb.delete();
      exp_rej = 0; exp_last = 0;
      cur_avg = 0; cur_filled = 1'b0; cur_near = 1'b0; mnear = 1'b0;
    end
    repeat (3) tick();
    check("reject_cnt", {24'd0, reject_cnt}, 32'(exp_rej));
    if (mode != 1) check("last_raw", {12'd0, last_raw}, 32'(exp_last));
    check("avg_hold", {12'd0, avg_cm}, 32'(cur_avg));
    check("filled", {31'd0, filled}, {31'd0, cur_filled});
    check("near", {31'd0, near}, {31'd0, cur_near});
    check("sb_pending", 32'(sb.size()), 32'd0);
  endtask

  int   alarm_val [5] = '{30, 18, 22, 24, 25};
`ifdef DIST_FILTER_ALARM_EN
  bit   alarm_exp [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
`else
  bit   alarm_exp [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif

  initial begin
    rst = 1'b1;
    ready = 1'b1;
    distance_cm = 20'd0;
    flush = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    distance_cm = 20'd77;
    repeat (100) tick();
    check_all_zero("idle_ready_high");

    measure(100, 0);
    measure(104, 0);
    measure(96, 0);
    check("no_valid_before_n", {12'd0, avg_cm}, 32'd0);
    measure(100, 0);
    check("avg_first", {12'd0, avg_cm}, 32'd100);
    check("filled_first", {31'd0, filled}, 32'd1);
    measure(200, 0);
    check("avg_fifth", {12'd0, avg_cm}, 32'd125);

    measure(0, 0);
    check("rej_one", {24'd0, reject_cnt}, 32'd1);
    check("last_raw_zero", {12'd0, last_raw}, 32'd0);
    measure(500, 0);
    check("rej_two", {24'd0, reject_cnt}, 32'd2);
    check("last_raw_500", {12'd0, last_raw}, 32'd500);
    check("avg_unchanged", {12'd0, avg_cm}, 32'd125);
    for (int i = 0; i < 298; i++) measure((i % 2) ? 401 : 0, 0);
    check("rej_saturated", {24'd0, reject_cnt}, 32'd255);

    for (int g = 0; g < 5; g++) begin
      for (int k = 0; k < 4; k++) measure(alarm_val[g], 0);
      check("alarm_avg", {12'd0, avg_cm}, 32'(alarm_val[g]));
      check("alarm_near", {31'd0, near}, {31'd0, alarm_exp[g]});
    end

    measure(400, 0);
    measure(1, 0);

    measure(50, 1);
    check("flush_filled", {31'd0, filled}, 32'd0);
    check("flush_avg", {12'd0, avg_cm}, 32'd0);
    check("flush_rej_kept", {24'd0, reject_cnt}, 32'd255);
    measure(10, 0);
    measure(20, 0);
    measure(30, 0);
    check("flush_no_early_valid", {31'd0, filled}, 32'd0);
    measure(40, 0);
    check("flush_refill_avg", {12'd0, avg_cm}, 32'd25);

    measure(60, 2);
    check_all_zero("after_rst");
    measure(8, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
